// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types for the core memory arbiter
//
// Purpose: operation codes, access size codes, arbiter FSM states and the
//          latched request record used by core_mem_arb and its sub-module.
// Ports:   none (package).

package sel_core_pkg;

   localparam int CORE_AW = 32;
   localparam int CORE_DW = 32;

   typedef enum logic [2:0] {
      COP_RD    = 3'd0,
      COP_WR    = 3'd1,
      COP_FETCH = 3'd2
   } cop_t;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [CORE_AW-1:0]   addr;
      cop_t                 cop;
      logic [CORE_DW-1:0]   wdata;
      logic [2:0]           size;
      logic [CORE_DW/8-1:0] be;
   } core_req_t;

endpackage

// File: rtl/core_mem_arb_if.sv
// rtl/core_mem_arb_if.sv - core request/ack bus
//
// Purpose: one request/ack channel between a requester and a responder.
// Signals: req_val/addr/cop/wdata/size/be (requester -> responder),
//          ack_val/ack_rdata/ack_err (responder -> requester).
// Modports: master = request issuer, slave = request responder.
//          The memory side never reports errors, so master omits ack_err;
//          the error flag is produced only by the arbiter's watchdog.

interface core_mem_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              req_val;
   logic [AW-1:0]     req_addr;
   logic [2:0]        req_cop;
   logic [DW-1:0]     req_wdata;
   logic [2:0]        req_size;
   logic [DW/8-1:0]   req_be;
   logic              ack_val;
   logic [DW-1:0]     ack_rdata;
   logic              ack_err;

   modport master (
      output req_val, req_addr, req_cop, req_wdata, req_size, req_be,
      input  ack_val, ack_rdata
   );

   modport slave (
      input  req_val, req_addr, req_cop, req_wdata, req_size, req_be,
      output ack_val, ack_rdata, ack_err
   );
endinterface

// File: rtl/core_rr_arb2.sv
// rtl/core_rr_arb2.sv - two-way round-robin picker
//
// Purpose: choose one of two requesters; on a tie the port that was not
//          granted last wins.
// Ports:   req[1:0] in  request lines
//          last     in  index of the port granted most recently
//          gnt[1:0] out one-hot grant (zero when no request)

module core_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last)) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

endmodule

// File: rtl/core_mem_arb.sv
// rtl/core_mem_arb.sv - two-port core request arbiter onto one memory port
//
// Purpose: shares one downstream memory port between instruction fetch
//          (port 0) and data access (port 1); round-robin grant, one
//          transaction in flight, ack routed to the owner, watchdog error ack.
// Ports:   clk  in  clock, rising edge
//          rst  in  synchronous reset, active high
//          p0   slave  instruction-fetch requester channel
//          p1   slave  data load/store requester channel
//          m    master downstream memory channel

module core_mem_arb
   import sel_core_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int TIMEOUT  = 256,
   parameter bit P0_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   core_mem_arb_if.slave  p0,
   core_mem_arb_if.slave  p1,
   core_mem_arb_if.master m
);

   localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   // Reset pretends the non-favoured port was served last so the favoured
   // port wins the first tie.
   localparam logic LAST_RST = P0_FIRST ? 1'b1 : 1'b0;

   if (AW != CORE_AW || DW != CORE_DW) begin : g_width_check
      $error("core_mem_arb: AW/DW must match sel_core_pkg widths");
   end

   arb_state_t     state_q, state_d;
   core_req_t      req_q, win;
   logic           owner_q;
   logic           last_q;
   logic [WDW-1:0] wd_q;
   logic [1:0]     gnt;
   logic           timeout_hit;
   logic           pass_ack;
   logic           ack_fire;
   logic           err_fire;
   logic [DW-1:0]  ack_data;

   core_rr_arb2 u_rr (
      .req  ({p1.req_val, p0.req_val}),
      .last (last_q),
      .gnt  (gnt)
   );

   // Fields of the winning requester, latched on the grant cycle.
   always_comb begin
      win.addr  = gnt[1] ? p1.req_addr  : p0.req_addr;
      win.cop   = cop_t'(gnt[1] ? p1.req_cop : p0.req_cop);
      win.wdata = gnt[1] ? p1.req_wdata : p0.req_wdata;
      win.size  = gnt[1] ? p1.req_size  : p0.req_size;
      win.be    = gnt[1] ? p1.req_be    : p0.req_be;
   end

   assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|gnt) state_d = BUSY;
         BUSY: begin
            // A downstream ack beats a simultaneous watchdog expiry.
            if (m.ack_val)        state_d = IDLE;
            else if (timeout_hit) state_d = ERR;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= LAST_RST;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && (|gnt)) begin
            req_q   <= win;
            owner_q <= gnt[1];
            last_q  <= gnt[1];
            wd_q    <= '0;
         end else if (state_q == BUSY && wd_q != '1) begin
            wd_q <= wd_q + 1'b1;
         end
      end
   end

   // Acks are suppressed while rst is high so a reset mid-transaction
   // never completes anything upstream.
   assign pass_ack = !rst && (state_q == BUSY) && m.ack_val;
   assign err_fire = !rst && (state_q == ERR);
   assign ack_fire = pass_ack || err_fire;
   assign ack_data = pass_ack ? m.ack_rdata : '0;

   assign p0.ack_val   = ack_fire && !owner_q;
   assign p1.ack_val   = ack_fire &&  owner_q;
   assign p0.ack_err   = err_fire && !owner_q;
   assign p1.ack_err   = err_fire &&  owner_q;
   assign p0.ack_rdata = !owner_q ? ack_data : '0;
   assign p1.ack_rdata =  owner_q ? ack_data : '0;

   assign m.req_val   = (state_q == BUSY);
   assign m.req_addr  = req_q.addr;
   assign m.req_cop   = req_q.cop;
   assign m.req_wdata = req_q.wdata;
   assign m.req_size  = req_q.size;
   assign m.req_be    = req_q.be;

endmodule

// File: tb/tb_core_mem_arb.sv
// tb/tb_core_mem_arb.sv - directed bench for core_mem_arb

module tb_core_mem_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   core_mem_arb_if #(.AW(32), .DW(32)) p0_if ();
   core_mem_arb_if #(.AW(32), .DW(32)) p1_if ();
   core_mem_arb_if #(.AW(32), .DW(32)) m_if ();

   core_mem_arb #(
      .AW(32), .DW(32), .TIMEOUT(8), .P0_FIRST(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .p0  (p0_if),
      .p1  (p1_if),
      .m   (m_if)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      p0_if.req_val = 0; p0_if.req_addr = 0; p0_if.req_cop = 0;
      p0_if.req_wdata = 0; p0_if.req_size = 0; p0_if.req_be = 0;
      p1_if.req_val = 0; p1_if.req_addr = 0; p1_if.req_cop = 0;
      p1_if.req_wdata = 0; p1_if.req_size = 0; p1_if.req_be = 0;
      m_if.ack_val = 0; m_if.ack_rdata = 0; m_if.ack_err = 0;

      // reset state
      step(); step();
      check("rst_m_req_val", m_if.req_val, 1'b0);
      check("rst_m_req_addr", m_if.req_addr, 32'h0);
      check("rst_p0_ack", p0_if.ack_val, 1'b0);
      check("rst_p1_ack", p1_if.ack_val, 1'b0);
      check("rst_p0_err", p0_if.ack_err, 1'b0);
      check("rst_p0_rdata", p0_if.ack_rdata, 32'h0);
      rst = 0;

      // 1: p0 read alone, downstream answers 3 cycles after m_req_val
      p0_if.req_val = 1; p0_if.req_addr = 32'h100; p0_if.req_cop = 3'd0;
      p0_if.req_size = 3'd2; p0_if.req_be = 4'hF;
      #1 check("t1_req_not_yet", m_if.req_val, 1'b0);
      step();
      check("t1_m_req_val", m_if.req_val, 1'b1);
      check("t1_m_req_addr", m_if.req_addr, 32'h100);
      check("t1_m_req_cop", m_if.req_cop, 3'd0);
      step(); step(); step();
      check("t1_no_early_ack", p0_if.ack_val, 1'b0);
      m_if.ack_val = 1; m_if.ack_rdata = 32'hDEADBEEF;
      #1;
      check("t1_p0_ack", p0_if.ack_val, 1'b1);
      check("t1_p0_rdata", p0_if.ack_rdata, 32'hDEADBEEF);
      check("t1_p0_err", p0_if.ack_err, 1'b0);
      check("t1_p1_ack", p1_if.ack_val, 1'b0);
      step();
      m_if.ack_val = 0; p0_if.req_val = 0;
      check("t1_m_req_drop", m_if.req_val, 1'b0);
      check("t1_p0_ack_gone", p0_if.ack_val, 1'b0);

      // 2: both requesters held from reset, grant order 0,1,0,1
      rst = 1; step(); rst = 0;
      p0_if.req_val = 1; p0_if.req_addr = 32'h1000; p0_if.req_cop = 3'd2;
      p1_if.req_val = 1; p1_if.req_addr = 32'h2000; p1_if.req_cop = 3'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("t2_req_val_%0d", i), m_if.req_val, 1'b1);
         check($sformatf("t2_addr_%0d", i), m_if.req_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
         m_if.ack_val = 1; m_if.ack_rdata = 32'h10 + i;
         #1;
         check($sformatf("t2_p0_ack_%0d", i), p0_if.ack_val, (i % 2 == 0) ? 1'b1 : 1'b0);
         check($sformatf("t2_p1_ack_%0d", i), p1_if.ack_val, (i % 2 == 1) ? 1'b1 : 1'b0);
         step();
         m_if.ack_val = 0;
         check($sformatf("t2_idle_%0d", i), m_if.req_val, 1'b0);
      end
      p0_if.req_val = 0; p1_if.req_val = 0;

      // 3: p1 write, fields latched and held while the requester changes them
      p1_if.req_val = 1; p1_if.req_addr = 32'h200; p1_if.req_cop = 3'd1;
      p1_if.req_wdata = 32'h12345678; p1_if.req_size = 3'd2; p1_if.req_be = 4'b0011;
      step();
      check("t3_req_val", m_if.req_val, 1'b1);
      check("t3_addr", m_if.req_addr, 32'h200);
      check("t3_cop", m_if.req_cop, 3'd1);
      check("t3_wdata", m_if.req_wdata, 32'h12345678);
      check("t3_size", m_if.req_size, 3'd2);
      check("t3_be", m_if.req_be, 4'b0011);
      p1_if.req_addr = 32'h999; p1_if.req_wdata = 32'h0;
      step();
      check("t3_addr_held", m_if.req_addr, 32'h200);
      check("t3_wdata_held", m_if.req_wdata, 32'h12345678);
      m_if.ack_val = 1; m_if.ack_rdata = 32'h0;
      #1;
      check("t3_p1_ack", p1_if.ack_val, 1'b1);
      check("t3_p0_ack", p0_if.ack_val, 1'b0);
      step();
      m_if.ack_val = 0; p1_if.req_val = 0;
      check("t3_req_drop", m_if.req_val, 1'b0);

      // 4: watchdog (TIMEOUT=8), then a late downstream ack is dropped
      p0_if.req_val = 1; p0_if.req_addr = 32'h300; p0_if.req_cop = 3'd0;
      step();
      check("t4_req_val", m_if.req_val, 1'b1);
      repeat (7) step();
      check("t4_no_ack_at_7", p0_if.ack_val, 1'b0);
      step();
      check("t4_err_ack", p0_if.ack_val, 1'b1);
      check("t4_err_flag", p0_if.ack_err, 1'b1);
      check("t4_err_rdata", p0_if.ack_rdata, 32'h0);
      check("t4_err_req_val", m_if.req_val, 1'b0);
      check("t4_p1_quiet", p1_if.ack_val, 1'b0);
      p0_if.req_val = 0;
      step();
      m_if.ack_val = 1; m_if.ack_rdata = 32'hAAAA;
      #1;
      check("t4_late_p0", p0_if.ack_val, 1'b0);
      check("t4_late_p1", p1_if.ack_val, 1'b0);
      step();
      m_if.ack_val = 0;

      // 6: ack in the same cycle the watchdog would expire
      p0_if.req_val = 1; p0_if.req_addr = 32'h400;
      step();
      repeat (7) step();
      m_if.ack_val = 1; m_if.ack_rdata = 32'h55;
      #1;
      check("t6_ack", p0_if.ack_val, 1'b1);
      check("t6_err", p0_if.ack_err, 1'b0);
      check("t6_rdata", p0_if.ack_rdata, 32'h55);
      step();
      m_if.ack_val = 0; p0_if.req_val = 0;
      check("t6_no_err_after", p0_if.ack_val, 1'b0);
      check("t6_idle", m_if.req_val, 1'b0);

      // 5: reset while BUSY, then first grant follows P0_FIRST
      p1_if.req_val = 1; p1_if.req_addr = 32'h500;
      step();
      check("t5_busy", m_if.req_val, 1'b1);
      rst = 1;
      step();
      check("t5_req_val_rst", m_if.req_val, 1'b0);
      check("t5_addr_rst", m_if.req_addr, 32'h0);
      check("t5_p1_no_ack", p1_if.ack_val, 1'b0);
      rst = 0;
      p0_if.req_val = 1; p0_if.req_addr = 32'h600;
      step();
      check("t5_first_grant", m_if.req_addr, 32'h600);
      m_if.ack_val = 1;
      #1;
      check("t5_p0_ack", p0_if.ack_val, 1'b1);
      check("t5_p1_ack", p1_if.ack_val, 1'b0);
      step();
      m_if.ack_val = 0; p0_if.req_val = 0; p1_if.req_val = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
